// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one pipelined divider among K
// requesters. A tag pipeline that runs alongside the divider returns each
// result to the requester that issued it. A zero divisor still occupies a
// pipeline slot, so results keep their issue order, and comes back as a
// flagged, saturated result.
//
// divider: restoring divider with one quotient bit per stage, N stages.
// out_valid follows in_valid by exactly N cycles.

module divider #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    input  logic [N-1:0] in_dividend,
    input  logic [M-1:0] in_divisor,
    output logic         out_valid,
    output logic [N-1:0] out_quotient,
    output logic [M-1:0] out_remainder
);

    // Each stage keeps the partial remainder and a combined word. Dividend
    // bits shift out at the top of that word and quotient bits shift in at
    // the bottom.
    logic         s_valid [N];
    logic [M-1:0] s_rem   [N];
    logic [N-1:0] s_dq    [N];
    logic [M-1:0] s_div   [N-1];

    function automatic logic [M+N-1:0] div_step(
        input logic [M-1:0] rem,
        input logic [N-1:0] dq,
        input logic [M-1:0] dvs
    );
        logic [M:0] trial;
        logic [M:0] diff;
        trial = {rem, dq[N-1]};
        diff  = trial - {1'b0, dvs};
        if (trial >= {1'b0, dvs})
            return {diff[M-1:0], dq[N-2:0], 1'b1};
        else
            return {trial[M-1:0], dq[N-2:0], 1'b0};
    endfunction

    // Advance the division pipeline by one quotient bit per stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < N; k++) begin
                s_valid[k] <= 1'b0;
                s_rem[k]   <= '0;
                s_dq[k]    <= '0;
            end
            for (int k = 0; k < N-1; k++) begin
                s_div[k] <= '0;
            end
        end else begin
            s_valid[0]          <= in_valid;
            {s_rem[0], s_dq[0]} <= div_step('0, in_dividend, in_divisor);
            s_div[0]            <= in_divisor;
            for (int k = 1; k < N; k++) begin
                s_valid[k]          <= s_valid[k-1];
                {s_rem[k], s_dq[k]} <= div_step(s_rem[k-1], s_dq[k-1], s_div[k-1]);
            end
            for (int k = 1; k < N-1; k++) begin
                s_div[k] <= s_div[k-1];
            end
        end
    end

    assign out_valid     = s_valid[N-1];
    assign out_quotient  = s_dq[N-1];
    assign out_remainder = s_rem[N-1];

endmodule

module divider_arbiter #(
    parameter int N = 8,
    parameter int M = 8,
    parameter int K = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [K-1:0]             req_valid,
    output logic [K-1:0]             req_ready,
    input  logic [K*N-1:0]           req_dividend,
    input  logic [K*M-1:0]           req_divisor,
    output logic [K-1:0]             rsp_valid,
    output logic [N-1:0]             rsp_quotient,
    output logic [M-1:0]             rsp_remainder,
    output logic                     rsp_div_zero,
    output logic                     busy,
    output logic [$clog2(N+3)-1:0]   inflight
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;

    logic [IW-1:0] ptr;
    logic          grant_any;
    logic [IW-1:0] grant_idx;
    int            cand;
    logic [N-1:0]  sel_dividend;
    logic [M-1:0]  sel_divisor;

    logic          iss_valid;
    logic [N-1:0]  iss_dividend;
    logic [M-1:0]  iss_divisor;
    logic [IW-1:0] iss_idx;
    logic          iss_zero;

    logic          tag_valid [N];
    logic [IW-1:0] tag_idx   [N];
    logic          tag_zero  [N];
    logic [M-1:0]  tag_zdata [N];

    logic          div_resetn;
    logic          div_out_valid;
    logic [N-1:0]  div_quotient;
    logic [M-1:0]  div_remainder;

    // Round-robin search starting one past the last grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (en && !reset) begin
            for (int off = 1; off <= K; off++) begin
                cand = (int'(ptr) + off) % K;
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = IW'(cand);
                end
            end
        end
    end

    // Decode the grant into the one-hot ready vector.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < K; i++) begin
            req_ready[i] = grant_any && (grant_idx == IW'(i));
        end
    end

    assign sel_dividend = req_dividend[int'(grant_idx)*N +: N];
    assign sel_divisor  = req_divisor[int'(grant_idx)*M +: M];

    // Move the pointer to the requester that was just granted.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= IW'(K-1);
        else if (grant_any)
            ptr <= grant_idx;
    end

    // Issue register. A zero divisor is replaced by 1 so that the divider
    // always sees a legal operand. The result is overridden on return.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid    <= 1'b0;
            iss_dividend <= '0;
            iss_divisor  <= '0;
            iss_idx      <= '0;
            iss_zero     <= 1'b0;
        end else begin
            iss_valid    <= grant_any;
            iss_dividend <= sel_dividend;
            iss_zero     <= (sel_divisor == '0);
            iss_divisor  <= (sel_divisor == '0) ? M'(1) : sel_divisor;
            iss_idx      <= grant_idx;
        end
    end

    assign div_resetn = ~reset;

    divider #(.N(N), .M(M)) u_divider (
        .clk           (clk),
        .resetn        (div_resetn),
        .in_valid      (iss_valid),
        .in_dividend   (iss_dividend),
        .in_divisor    (iss_divisor),
        .out_valid     (div_out_valid),
        .out_quotient  (div_quotient),
        .out_remainder (div_remainder)
    );

    // Tag pipeline in lockstep with the divider stages. The dividend is
    // carried only for zero-divisor ops, where it becomes the remainder.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                tag_valid[k] <= 1'b0;
                tag_idx[k]   <= '0;
                tag_zero[k]  <= 1'b0;
                tag_zdata[k] <= '0;
            end
        end else begin
            tag_valid[0] <= iss_valid;
            tag_idx[0]   <= iss_idx;
            tag_zero[0]  <= iss_zero;
            tag_zdata[0] <= iss_zero ? iss_dividend[M-1:0] : '0;
            for (int k = 1; k < N; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_idx[k]   <= tag_idx[k-1];
                tag_zero[k]  <= tag_zero[k-1];
                tag_zdata[k] <= tag_zdata[k-1];
            end
        end
    end

    // Return register: send the result to the owner named in the tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid     <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div_zero  <= 1'b0;
        end else begin
            for (int i = 0; i < K; i++) begin
                rsp_valid[i] <= div_out_valid && (tag_idx[N-1] == IW'(i));
            end
            if (div_out_valid) begin
                rsp_div_zero  <= tag_zero[N-1];
                rsp_quotient  <= tag_zero[N-1] ? '1 : div_quotient;
                rsp_remainder <= tag_zero[N-1] ? tag_zdata[N-1] : div_remainder;
            end
        end
    end

    // Count of operations that were accepted and have not yet returned.
    always_ff @(posedge clk) begin
        if (reset)
            inflight <= '0;
        else if (grant_any && !(|rsp_valid))
            inflight <= inflight + 1'b1;
        else if (!grant_any && (|rsp_valid))
            inflight <= inflight - 1'b1;
    end

    assign busy = (inflight != '0);

    // The tag pipeline and the divider must never disagree about a valid slot.
    always @(posedge clk) begin
        if (!reset)
            assert (tag_valid[N-1] == div_out_valid);
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with the default configuration
// (N=8, M=8, K=3). Inputs change 1 ns after each rising edge, and outputs
// are checked after that.

module tb_divider_arbiter;

    localparam int N = 8;
    localparam int M = 8;
    localparam int K = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic [K-1:0]   req_valid;
    logic [K-1:0]   req_ready;
    logic [K*N-1:0] req_dividend;
    logic [K*M-1:0] req_divisor;
    logic [K-1:0]   rsp_valid;
    logic [N-1:0]   rsp_quotient;
    logic [M-1:0]   rsp_remainder;
    logic           rsp_div_zero;
    logic           busy;
    logic [3:0]     inflight;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    divider_arbiter #(.N(N), .M(M), .K(K)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_div_zero  (rsp_div_zero),
        .busy          (busy),
        .inflight      (inflight)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [N-1:0] dd, input logic [M-1:0] dv);
        req_dividend[i*N +: N] = dd;
        req_divisor[i*M +: M]  = dv;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        reset     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t4_q [4] = '{7, 8, 10, 11};
        int t4_r [4] = '{1, 4, 0, 3};
        int t6_dd[4] = '{255, 0, 255, 7};
        int t6_dv[4] = '{255, 1, 1, 255};
        int t6_q [4] = '{1, 0, 255, 0};
        int t6_r [4] = '{0, 0, 0, 7};
        int seen;

        // Reset values, with all requesters valid while reset is held.
        reset        = 1'b1;
        en           = 1'b1;
        req_valid    = '1;
        req_dividend = '0;
        req_divisor  = '0;
        tick();
        tick();
        settle();
        chk("rst_ready",    req_ready,     0);
        chk("rst_rsp",      rsp_valid,     0);
        chk("rst_quot",     rsp_quotient,  0);
        chk("rst_rem",      rsp_remainder, 0);
        chk("rst_dz",       rsp_div_zero,  0);
        chk("rst_busy",     busy,          0);
        chk("rst_inflight", inflight,      0);
        req_valid = '0;
        reset     = 1'b0;

        // Single op: 29/5 from requester 1 returns 10 cycles after the accept.
        set_req(1, 8'd29, 8'd5);
        req_valid = 3'b010;
        settle();
        chk("t1_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        chk("t1_inflight1", inflight, 1);
        chk("t1_busy1",     busy,     1);
        for (int c = 1; c < 10; c++) begin
            chk("t1_early", rsp_valid, 0);
            tick();
        end
        chk("t1_rsp",  rsp_valid,     3'b010);
        chk("t1_quot", rsp_quotient,  5);
        chk("t1_rem",  rsp_remainder, 4);
        chk("t1_dz",   rsp_div_zero,  0);
        tick();
        chk("t1_rsp_off",   rsp_valid, 0);
        chk("t1_inflight0", inflight,  0);
        chk("t1_busy0",     busy,      0);

        // Full contention: grants rotate 0,1,2 and results follow that order.
        do_reset();
        for (int i = 0; i < K; i++) set_req(i, N'(200 + i), 8'd7);
        req_valid = 3'b111;
        for (int i = 0; i < 9; i++) begin
            settle();
            chk("t2_grant", req_ready, 32'd1 << (i % 3));
            tick();
        end
        req_valid = '0;
        chk("t2_inflight9", inflight, 9);
        tick();
        for (int j = 0; j < 9; j++) begin
            chk("t2_rsp",  rsp_valid,     32'd1 << (j % 3));
            chk("t2_quot", rsp_quotient,  28);
            chk("t2_rem",  rsp_remainder, 4 + (j % 3));
            chk("t2_dz",   rsp_div_zero,  0);
            tick();
        end
        chk("t2_rsp_off",   rsp_valid, 0);
        chk("t2_inflight0", inflight,  0);

        // Zero divisor followed by a normal op.
        do_reset();
        set_req(2, 8'hA5, 8'd0);
        req_valid = 3'b100;
        settle();
        chk("t3_ready2", req_ready, 3'b100);
        tick();
        set_req(0, 8'd100, 8'd10);
        req_valid = 3'b001;
        settle();
        chk("t3_ready0", req_ready, 3'b001);
        tick();
        req_valid = '0;
        repeat (8) tick();
        chk("t3_z_rsp",  rsp_valid,     3'b100);
        chk("t3_z_dz",   rsp_div_zero,  1);
        chk("t3_z_quot", rsp_quotient,  8'hFF);
        chk("t3_z_rem",  rsp_remainder, 8'hA5);
        tick();
        chk("t3_n_rsp",  rsp_valid,     3'b001);
        chk("t3_n_quot", rsp_quotient,  10);
        chk("t3_n_rem",  rsp_remainder, 0);
        chk("t3_n_dz",   rsp_div_zero,  0);

        // Dropping en with 4 ops in flight: no new grants, and all 4 results return.
        do_reset();
        req_valid = 3'b001;
        for (int i = 0; i < 4; i++) begin
            set_req(0, N'(50 + 10 * i), 8'd7);
            settle();
            chk("t4_ready", req_ready, 3'b001);
            tick();
        end
        en = 1'b0;
        set_req(0, 8'd90, 8'd7);
        for (int c = 4; c < 10; c++) begin
            settle();
            chk("t4_gated", req_ready, 0);
            chk("t4_early", rsp_valid, 0);
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            settle();
            chk("t4_rsp",   rsp_valid,     3'b001);
            chk("t4_quot",  rsp_quotient,  t4_q[j]);
            chk("t4_rem",   rsp_remainder, t4_r[j]);
            chk("t4_gated", req_ready,     0);
            if (j == 3) chk("t4_busy_last", busy, 1);
            tick();
        end
        chk("t4_busy0",     busy,      0);
        chk("t4_inflight0", inflight,  0);
        chk("t4_rsp_off",   rsp_valid, 0);
        req_valid = '0;
        en        = 1'b1;

        // Reset mid-flight: accepted ops are discarded and priority returns to requester 0.
        do_reset();
        req_valid = 3'b010;
        for (int i = 0; i < 5; i++) begin
            set_req(1, N'(20 + i), 8'd3);
            settle();
            chk("t5_ready", req_ready, 3'b010);
            tick();
        end
        reset     = 1'b1;
        req_valid = 3'b111;
        settle();
        chk("t5_rst_ready", req_ready, 0);
        tick();
        reset     = 1'b0;
        req_valid = '0;
        chk("t5_inflight0", inflight,  0);
        chk("t5_busy0",     busy,      0);
        chk("t5_rsp0",      rsp_valid, 0);
        seen = 0;
        repeat (14) begin
            if (rsp_valid != '0) seen++;
            tick();
        end
        chk("t5_no_rsp", seen, 0);
        set_req(0, 8'd9, 8'd2);
        set_req(1, 8'd9, 8'd3);
        set_req(2, 8'd9, 8'd4);
        req_valid = 3'b111;
        settle();
        chk("t5_first_grant", req_ready, 3'b001);
        tick();
        req_valid = '0;
        repeat (9) tick();
        chk("t5_rsp",  rsp_valid,     3'b001);
        chk("t5_quot", rsp_quotient,  4);
        chk("t5_rem",  rsp_remainder, 1);

        // Edge operand values, issued back to back.
        do_reset();
        req_valid = 3'b001;
        for (int i = 0; i < 4; i++) begin
            set_req(0, N'(t6_dd[i]), M'(t6_dv[i]));
            settle();
            chk("t6_ready", req_ready, 3'b001);
            tick();
        end
        req_valid = '0;
        repeat (6) tick();
        for (int j = 0; j < 4; j++) begin
            chk("t6_rsp",  rsp_valid,     3'b001);
            chk("t6_quot", rsp_quotient,  t6_q[j]);
            chk("t6_rem",  rsp_remainder, t6_r[j]);
            chk("t6_dz",   rsp_div_zero,  0);
            tick();
        end
        chk("t6_inflight0", inflight, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
